// File: rtl/uart_pkg.sv
// Shared UART receive types, the default bit period and the parity helper.
package uart_pkg;

  localparam int CYCLE_uart = 434;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  // Bit value that makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the asynchronous serial input; resets to the idle level (1).
module rx_sync (
  input  logic clk,
  input  logic res,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/receiver.sv
// UART receive path: 8N1 deserialiser feeding an active-low FIFO write strobe.
// Optional 8E1 parity checking when the RX_PARITY_EN macro is defined.
module receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CYCLE_uart,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       res,
  input  logic       uart_rx,
  output logic [7:0] port,
  output logic       wen_n,
  input  logic       is_full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_M1  = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_B  = 3'(DATA_BITS - 1);

  logic rxs;

  rx_sync u_sync (
    .clk (clk),
    .res (res),
    .d_i (uart_rx),
    .q_o (rxs)
  );

  rx_state_t     state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    port_q, port_d;
  logic          wen_n_q, wen_n_d;
  logic          fe_q, fe_d;
  logic          ov_q, ov_d;
  logic          par_ok;
`ifdef RX_PARITY_EN
  logic          par_ok_q, par_ok_d;
  assign par_ok = par_ok_q;
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      port_q  <= 8'h00;
      wen_n_q <= 1'b1;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef RX_PARITY_EN
      par_ok_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      port_q  <= port_d;
      wen_n_q <= wen_n_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
`ifdef RX_PARITY_EN
      par_ok_q <= par_ok_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    port_d  = port_q;
    wen_n_d = 1'b1;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
`ifdef RX_PARITY_EN
    par_ok_d = par_ok_q;
`endif
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        bit_d = '0;
        if (!rxs) state_d = START;
      end
      // Start bit must still be low at mid-bit, otherwise it was a glitch.
      START: begin
        if (tmr_q == HALF_M1) begin
          tmr_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tmr_q == BIT_M1) begin
          tmr_d = '0;
          sh_d  = {rxs, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == LAST_B) begin
`ifdef RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (tmr_q == BIT_M1) begin
          tmr_d    = '0;
          par_ok_d = (rxs == even_parity(sh_q));
          state_d  = STOP;
        end
      end
`endif
      // Decision at mid-stop so the next start edge half a bit later is caught.
      STOP: begin
        if (tmr_q == BIT_M1) begin
          tmr_d = '0;
          if (!rxs) begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end else if (!par_ok) begin
            fe_d    = 1'b1;
            state_d = IDLE;
          end else if (is_full) begin
            ov_d    = 1'b1;
            state_d = IDLE;
          end else begin
            wen_n_d = 1'b0;
            port_d  = sh_q;
            state_d = IDLE;
          end
        end
      end
      BREAK: begin
        tmr_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        tmr_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign port      = port_q;
  assign wen_n     = wen_n_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;

endmodule
